nvram_upload: RTL and testbench
===============================

// Module: nvram_upload
//
// PURPOSE
//   Responder for the HPS ioctl *upload* (read-back) direction: serves ioctl_rd requests with bytes
//   read from the core's battery/high-score NVRAM so the framework can save them to SD.
//   Sits beside the ROM download path in the emu top. Freezes the game CPU via pause_req/pause_ack,
//   arbitrates the NVRAM second port and stretches each HPS read with ioctl_wait.
//
// PARAMETERS
//   AW      12     NVRAM byte address width
//   SIZE    4096   number of valid NVRAM bytes (<= 2**AW)
//   RD_LAT  1      NVRAM read latency in clk_sys cycles (1..3)
//   IDX     8'd4   ioctl_index value that selects this block
//
// PORTS
//   clk_sys        in   1   system clock (40 MHz)
//   reset          in   1   asynchronous, active-high reset
//   ioctl_upload   in   1   HPS upload session active
//   ioctl_index    in   8   file index of current session
//   ioctl_rd       in   1   one-cycle read strobe from HPS
//   ioctl_addr     in   25  byte address of requested read, valid with ioctl_rd
//   ioctl_din      out  8   returned byte
//   ioctl_wait     out  1   HPS must hold off; ioctl_din not yet valid
//   pause_req      out  1   request CPU freeze / NVRAM port ownership
//   pause_ack      in   1   CPU frozen, NVRAM port granted
//   ram_addr       out  AW  NVRAM read address
//   ram_rd         out  1   NVRAM read strobe (one cycle)
//   ram_q          in   8   NVRAM data, valid RD_LAT cycles after ram_rd
//   busy           out  1   session in progress (state != IDLE)
//   done           out  1   one-cycle pulse when a session that reached READY ends
//
// BEHAVIOUR
//   - Reset: state IDLE. ioctl_din=8'h00; ioctl_wait, pause_req, ram_rd, busy, done = 0; ram_addr=0.
//   - States: IDLE, PAUSE, READY, FETCH.
//   - IDLE: on rising edge of ioctl_upload with ioctl_index==IDX -> PAUSE. pause_req=1, ioctl_wait=1,
//     busy=1 from the next cycle. A session with a non-matching index is ignored entirely.
//   - PAUSE: hold ioctl_wait=1. On pause_ack=1 -> READY; ioctl_wait drops the same cycle.
//   - READY: ioctl_rd at cycle N with ioctl_addr<SIZE -> FETCH. At N+1: ram_rd=1 (one cycle),
//     ram_addr=ioctl_addr[AW-1:0], ioctl_wait=1. ram_q sampled at N+1+RD_LAT. At N+2+RD_LAT:
//     ioctl_din updated, ioctl_wait=0, state READY. Total latency RD_LAT+2 cycles.
//   - ioctl_addr>=SIZE (no macro): ioctl_din=8'hFF at N+1, no ram_rd, ioctl_wait stays 0.
//   - Exactly one read outstanding; ioctl_rd during FETCH or PAUSE is ignored.
//   - pause_ack falling in READY or FETCH: abort any fetch, ioctl_wait=1, state PAUSE.
//   - ioctl_upload falling in any state: IDLE next cycle. pause_req=0, ioctl_wait=0, busy=0.
//     In-flight fetch data is discarded. done=1 for one cycle only if READY was reached.
//   - ioctl_din holds its last value between reads and across sessions.
//   - Rising and falling edges of ioctl_upload are detected on clk_sys using a registered copy.
//
// CONFIGURATION
//   NVRAM_CHECKSUM_EN defined:
//     - 8-bit sum register is cleared on entry to PAUSE from IDLE.
//     - Each in-range byte returned to HPS is added modulo 256.
//     - Read of addr==SIZE returns (~sum+1) with 1-cycle response, no ram_rd, so the file sums to 0.
//     - addr>SIZE returns 8'hFF.
//     - The checksum is valid only for in-order reads.
//   NVRAM_CHECKSUM_EN undefined: every addr>=SIZE returns 8'hFF; there is no sum logic.
//
// STRUCTURE
//   Package nvram_pkg:
//     - state enum nvram_state_t {IDLE, PAUSE, READY, FETCH}
//     - localparam NVRAM_FILL = 8'hFF
//     - default ioctl index NVRAM_IDX = 8'd4
//   Sub-module nvram_lat_pipe:
//     - RD_LAT-stage shift register carrying the ram_rd strobe
//     - produces the capture enable for ram_q
//     - cleared by abort and by reset
//
// TESTING
//   1. Reset mid-FETCH: all outputs return to reset values asynchronously; state is IDLE.
//   2. Session start, IDX=4: ioctl_index=4, ioctl_upload rises; pause_ack after 10 cycles ->
//      ioctl_wait is high for those 10 cycles, then drops; busy=1.
//   3. Single read, RD_LAT=1, RAM[0x010]=8'h5A: ioctl_rd with ioctl_addr=0x010 at N ->
//      ram_rd at N+1 with ram_addr=0x010; ioctl_din=8'h5A and ioctl_wait=0 at N+3.
//   4. Out-of-range read: ioctl_addr=SIZE+5 -> ioctl_din=8'hFF next cycle; ram_rd never asserted.
//   5. Checksum (macro on, SIZE=4, bytes 01 02 03 04): read addresses 0..4 in order -> addr 4 returns 8'hF6.
//      Macro off: addr 4 returns 8'hFF.
//   6. Abort and ignore cases:
//      - ioctl_upload drops during FETCH -> IDLE next cycle, pause_req=0, done pulses once,
//        ioctl_din unchanged.
//      - Session with ioctl_index=0 -> busy stays 0, done never pulses.

Source files
------------

// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload responder.
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH
    } nvram_state_t;

    // Byte returned for reads past the end of the NVRAM image
    localparam logic [7:0] NVRAM_FILL = 8'hFF;

    // ioctl_index that selects the NVRAM file
    localparam logic [7:0] NVRAM_IDX = 8'd4;

endpackage

// File: rtl/nvram_lat_pipe.sv
// Delay line for the NVRAM read strobe. Its last stage marks the cycle in which
// ram_q holds the requested byte. Clearing it drops a read that is in flight.
module nvram_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic strobe,
    output logic capture
);

    logic [RD_LAT-1:0] stages;

    // Shift the read strobe along one stage per clock; an abort empties the line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else if (clear) begin
            stages <= '0;
        end else begin
            stages[0] <= strobe;
            for (int i = 1; i < RD_LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign capture = stages[RD_LAT-1];

endmodule

// File: rtl/nvram_upload.sv
// HPS ioctl upload responder. It serves ioctl_rd requests with NVRAM bytes while
// the game CPU is frozen. Optional feature macro: NVRAM_CHECKSUM_EN. When it is
// defined, a read at addr==SIZE returns a byte that makes the uploaded file sum
// to zero modulo 256.
module nvram_upload
    import nvram_pkg::*;
#(
    parameter int          AW     = 12,
    parameter int          SIZE   = 4096,
    parameter int          RD_LAT = 1,
    parameter logic [7:0]  IDX    = NVRAM_IDX
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          busy,
    output logic          done
);

    localparam logic [24:0] SIZE_ADDR = 25'(SIZE);

    nvram_state_t state, next_state;

    logic upload_q;
    logic upload_rise;
    logic upload_fall;
    logic in_range;
    logic rd_accept;
    logic start_fetch;
    logic out_of_range;
    logic capture;
    logic abort;
    logic fetch_done;
    logic reached;

    assign upload_rise  = ioctl_upload & ~upload_q;
    assign upload_fall  = ~ioctl_upload & upload_q;
    assign in_range     = ioctl_addr < SIZE_ADDR;
    assign rd_accept    = (state == READY) & pause_ack & ~upload_fall & ioctl_rd;
    assign start_fetch  = rd_accept & in_range;
    assign out_of_range = rd_accept & ~in_range;
    assign abort        = (state == FETCH) & (upload_fall | ~pause_ack);
    assign fetch_done   = (state == FETCH) & pause_ack & ~upload_fall & capture;

    nvram_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_lat_pipe (
        .clk     (clk_sys),
        .reset   (reset),
        .clear   (abort),
        .strobe  (ram_rd),
        .capture (capture)
    );

    // State register plus the registered copy of ioctl_upload used for edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            upload_q <= 1'b0;
        end else begin
            state    <= next_state;
            upload_q <= ioctl_upload;
        end
    end

    // Next-state logic; the end of an upload session overrides everything else
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (upload_rise && (ioctl_index == IDX)) begin
                    next_state = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_ack) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (!pause_ack) begin
                    next_state = PAUSE;
                end else if (ioctl_rd && in_range) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (!pause_ack) begin
                    next_state = PAUSE;
                end else if (capture) begin
                    next_state = READY;
                end
            end
            default: next_state = IDLE;
        endcase
        if (upload_fall && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

    // Handshake outputs decoded from the state; wait releases as soon as the CPU acks
    always_comb begin
        busy       = (state != IDLE);
        pause_req  = (state != IDLE);
        ioctl_wait = ((state == PAUSE) && !pause_ack) || (state == FETCH);
    end

    // Read strobe/address, returned byte and session-complete pulse
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            ioctl_din <= 8'h00;
            done      <= 1'b0;
            reached   <= 1'b0;
        end else begin
            ram_rd <= start_fetch;
            if (start_fetch) begin
                ram_addr <= ioctl_addr[AW-1:0];
            end
            if (fetch_done) begin
                ioctl_din <= ram_q;
            end else if (out_of_range) begin
`ifdef NVRAM_CHECKSUM_EN
                if (ioctl_addr == SIZE_ADDR) begin
                    ioctl_din <= ~sum + 8'd1;
                end else begin
                    ioctl_din <= NVRAM_FILL;
                end
`else
                ioctl_din <= NVRAM_FILL;
`endif
            end
            done <= upload_fall & (reached | (state == READY) | (state == FETCH));
            if (state == IDLE) begin
                reached <= 1'b0;
            end else if (state == READY) begin
                reached <= 1'b1;
            end
        end
    end

`ifdef NVRAM_CHECKSUM_EN
    logic [7:0] sum;

    // Running modulo-256 sum of the in-range bytes handed to the HPS this session
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum <= 8'h00;
        end else if ((state == IDLE) && (next_state == PAUSE)) begin
            sum <= 8'h00;
        end else if (fetch_done) begin
            sum <= sum + ram_q;
        end
    end
`endif

endmodule

// File: tb/tb_nvram_upload.sv
// Self-checking bench for nvram_upload: random reads against a byte-array model
// of the NVRAM image, plus session, abort and reset scenarios.
module tb_nvram_upload;

    localparam int         AW     = 6;
    localparam int         SIZE   = 48;
    localparam int         RD_LAT = 1;
    localparam logic [7:0] IDX    = 8'd4;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          ioctl_upload = 1'b0;
    logic [7:0]    ioctl_index  = 8'd0;
    logic          ioctl_rd     = 1'b0;
    logic [24:0]   ioctl_addr   = '0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack    = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_q        = 8'h00;
    logic          busy;
    logic          done;

    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_din = 8'h00;
    logic [7:0] exp_sum = 8'h00;
    logic [7:0] mem [0:(1<<AW)-1];

    nvram_upload #(
        .AW     (AW),
        .SIZE   (SIZE),
        .RD_LAT (RD_LAT),
        .IDX    (IDX)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_q        (ram_q),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk_sys = ~clk_sys;

    // NVRAM second port: the byte appears one cycle after ram_rd, otherwise garbage
    always @(posedge clk_sys) begin
        if (ram_rd) ram_q <= mem[ram_addr];
        else        ram_q <= 8'($urandom);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Byte the HPS should receive for a given address under the file rules
    function automatic logic [7:0] expectedByte(input logic [24:0] addr);
        if (addr < SIZE) return mem[addr[AW-1:0]];
`ifdef NVRAM_CHECKSUM_EN
        if (addr == SIZE) return 8'(256 - int'(exp_sum));
`endif
        return 8'hFF;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_din"},      ioctl_din,  8'h00);
        checkOutput({tag, "_wait"},     ioctl_wait, 1'b0);
        checkOutput({tag, "_pause"},    pause_req,  1'b0);
        checkOutput({tag, "_ram_rd"},   ram_rd,     1'b0);
        checkOutput({tag, "_busy"},     busy,       1'b0);
        checkOutput({tag, "_done"},     done,       1'b0);
        checkOutput({tag, "_ram_addr"}, ram_addr,   '0);
    endtask

    task automatic startSession(input logic [7:0] idx, input int ack_delay);
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        tick();
        if (idx == IDX) begin
            exp_sum = 8'h00;
            for (int i = 0; i < ack_delay; i++) begin
                checkOutput("pause_busy", busy, 1'b1);
                checkOutput("pause_req", pause_req, 1'b1);
                checkOutput("pause_wait", ioctl_wait, 1'b1);
                tick();
            end
            pause_ack = 1'b1;
            #1;
            checkOutput("ack_wait_drop", ioctl_wait, 1'b0);
            tick();
            checkOutput("ready_wait", ioctl_wait, 1'b0);
            checkOutput("ready_busy", busy, 1'b1);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("ignore_busy", busy, 1'b0);
                checkOutput("ignore_pause", pause_req, 1'b0);
                checkOutput("ignore_done", done, 1'b0);
                tick();
            end
        end
    endtask

    task automatic endSession(input logic expect_done);
        ioctl_upload = 1'b0;
        pause_ack    = 1'b0;
        tick();
        checkOutput("end_busy", busy, 1'b0);
        checkOutput("end_pause", pause_req, 1'b0);
        checkOutput("end_wait", ioctl_wait, 1'b0);
        checkOutput("end_done", done, expect_done);
        tick();
        checkOutput("end_done_clear", done, 1'b0);
    endtask

    task automatic applyStimulus(input logic [24:0] addr, input bit double_rd);
        logic [7:0] exp;
        bit         hit;
        hit = (addr < SIZE);
        exp = expectedByte(addr);
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        tick();
        if (hit) begin
            if (double_rd) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = 25'($urandom_range(0, SIZE-1));
            end else begin
                ioctl_rd = 1'b0;
            end
            checkOutput("rd_strobe", ram_rd, 1'b1);
            checkOutput("rd_addr", ram_addr, addr[AW-1:0]);
            checkOutput("rd_wait", ioctl_wait, 1'b1);
            checkOutput("rd_din_hold", ioctl_din, exp_din);
            for (int k = 0; k < RD_LAT; k++) begin
                tick();
                ioctl_rd = 1'b0;
                checkOutput("rd_strobe_once", ram_rd, 1'b0);
                checkOutput("rd_wait_lat", ioctl_wait, 1'b1);
            end
            tick();
            checkOutput("rd_data", ioctl_din, exp);
            checkOutput("rd_wait_done", ioctl_wait, 1'b0);
            checkOutput("rd_strobe_idle", ram_rd, 1'b0);
            exp_din = exp;
            exp_sum = exp_sum + exp;
        end else begin
            ioctl_rd = 1'b0;
            checkOutput("oob_data", ioctl_din, exp);
            checkOutput("oob_wait", ioctl_wait, 1'b0);
            checkOutput("oob_no_rd", ram_rd, 1'b0);
            exp_din = exp;
            tick();
            checkOutput("oob_no_rd2", ram_rd, 1'b0);
            checkOutput("oob_hold", ioctl_din, exp);
        end
    endtask

    initial begin
        logic [24:0] addr;
        int          r;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[16] = 8'h5A;

        // Reset values
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        // Non-matching index is ignored
        startSession(8'd0, 0);
        endSession(1'b0);

        // Matching session, ack after 10 cycles
        startSession(IDX, 10);

        // Directed read and out-of-range read
        applyStimulus(25'h010, 1'b0);
        checkOutput("read_5a", ioctl_din, 8'h5A);
        applyStimulus(25'(SIZE + 5), 1'b0);

        // Random reads with idle gaps
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 25'($urandom) | 25'h100000;
            else if (r == 1) addr = 25'(SIZE + $urandom_range(0, 10));
            else             addr = 25'($urandom_range(0, SIZE-1));
            applyStimulus(addr, (addr < SIZE) && ($urandom_range(0, 3) == 0));
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                checkOutput("gap_hold", ioctl_din, exp_din);
                checkOutput("gap_wait", ioctl_wait, 1'b0);
                tick();
            end
        end

        // pause_ack drops during a fetch
        addr       = 25'($urandom_range(0, SIZE-1));
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        tick();
        ioctl_rd  = 1'b0;
        pause_ack = 1'b0;
        checkOutput("abort_rd", ram_rd, 1'b1);
        tick();
        checkOutput("abort_wait", ioctl_wait, 1'b1);
        checkOutput("abort_pause", pause_req, 1'b1);
        checkOutput("abort_din", ioctl_din, exp_din);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_hold_wait", ioctl_wait, 1'b1);
            checkOutput("abort_hold_din", ioctl_din, exp_din);
        end
        pause_ack = 1'b1;
        #1;
        checkOutput("reack_wait", ioctl_wait, 1'b0);
        tick();
        checkOutput("reack_din", ioctl_din, exp_din);
        applyStimulus(addr, 1'b0);
        endSession(1'b1);

        // Checksum session: read the whole file in order, then past the end
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        startSession(IDX, 2);
        for (int a = 0; a < SIZE; a++) applyStimulus(25'(a), 1'b0);
        applyStimulus(25'(SIZE), 1'b0);
        applyStimulus(25'(SIZE + 3), 1'b0);
        endSession(1'b1);

        // ioctl_upload drops during a fetch
        startSession(IDX, 1);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'($urandom_range(0, SIZE-1));
        tick();
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        pause_ack    = 1'b0;
        tick();
        checkOutput("drop_busy", busy, 1'b0);
        checkOutput("drop_pause", pause_req, 1'b0);
        checkOutput("drop_wait", ioctl_wait, 1'b0);
        checkOutput("drop_done", done, 1'b1);
        checkOutput("drop_din", ioctl_din, exp_din);
        tick();
        checkOutput("drop_done_once", done, 1'b0);
        checkOutput("drop_din_hold", ioctl_din, exp_din);
        checkOutput("drop_no_rd", ram_rd, 1'b0);

        // Asynchronous reset in the middle of a fetch
        startSession(IDX, 1);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'($urandom_range(0, SIZE-1));
        tick();
        ioctl_rd = 1'b0;
        checkOutput("mid_rd", ram_rd, 1'b1);
        #2;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        pause_ack    = 1'b0;
        #1;
        checkResetValues("async_reset");
        exp_din = 8'h00;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_reset_busy", busy, 1'b0);
        checkOutput("post_reset_din", ioctl_din, exp_din);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
